// File: rtl/data_sram_axi_bridge_if.sv
// AXI-side bus bundle for data_sram_axi_bridge.
// Carries the AR/R/AW/W/B channel signals (no id/len/burst/resp fields).
//   master : the bridge (drives addresses, valids, write data, rready/bready)
//   slave  : the AXI memory/interconnect side
interface data_sram_axi_bridge_if;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arsize, arvalid, rready,
    output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  araddr, arsize, arvalid, rready,
    input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/data_sram_axi_bridge.sv
// SRAM-style CPU data port to AXI bridge, one outstanding transaction.
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   data_sram_req/wr/size/wstrb/addr/wdata   CPU request (accepted when addr_ok)
//   data_sram_addr_ok        request accepted this cycle
//   data_sram_data_ok        read data valid / write complete (one cycle)
//   data_sram_rdata          registered read data
//   axi                      AXI channels (master modport)
module data_sram_axi_bridge (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          data_sram_req,
  input  logic                          data_sram_wr,
  input  logic [1:0]                    data_sram_size,
  input  logic [3:0]                    data_sram_wstrb,
  input  logic [31:0]                   data_sram_addr,
  input  logic [31:0]                   data_sram_wdata,
  output logic                          data_sram_addr_ok,
  output logic                          data_sram_data_ok,
  output logic [31:0]                   data_sram_rdata,
  data_sram_axi_bridge_if.master        axi
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] AR   = 3'd1;
  localparam logic [2:0] R    = 3'd2;
  localparam logic [2:0] AW   = 3'd3;
  localparam logic [2:0] B    = 3'd4;
  localparam logic [2:0] RESP = 3'd5;

  logic [2:0]  state, state_nxt;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        aw_done, w_done;
  logic        accept;
  logic        ar_hs, aw_hs, w_hs;
  logic [2:0]  axsize;

  // Direction of the transaction is held by the state itself (AR path vs AW path).
  // resetn gates accept so addr_ok stays low while reset is asserted.
  assign accept = resetn & (state == IDLE) & data_sram_req;
  assign ar_hs  = axi.arvalid & axi.arready;
  assign aw_hs  = axi.awvalid & axi.awready;
  assign w_hs   = axi.wvalid & axi.wready;

  // Size code 3 is not a legal CPU size; issue it as a word access.
  assign axsize = (size_q == 2'd3) ? 3'b010 : {1'b0, size_q};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = data_sram_wr ? AW : AR;
      AR:      if (ar_hs) state_nxt = R;
      R:       if (axi.rvalid) state_nxt = RESP;
      AW:      if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = B;
      B:       if (axi.bvalid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      size_q          <= '0;
      wstrb_q         <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      data_sram_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        size_q  <= data_sram_size;
        wstrb_q <= data_sram_wstrb;
        addr_q  <= data_sram_addr;
        wdata_q <= data_sram_wdata;
      end
      // Per-channel completion flags: set on own handshake, cleared on leaving AW.
      aw_done <= (state_nxt == AW) & (aw_done | aw_hs);
      w_done  <= (state_nxt == AW) & (w_done | w_hs);
      if ((state == R) && axi.rvalid) data_sram_rdata <= axi.rdata;
    end
  end

  assign data_sram_addr_ok = accept;
  assign data_sram_data_ok = (state == RESP);

  assign axi.araddr  = addr_q;
  assign axi.arsize  = axsize;
  assign axi.arvalid = (state == AR);
  assign axi.rready  = (state == R);
  assign axi.awaddr  = addr_q;
  assign axi.awsize  = axsize;
  assign axi.awvalid = (state == AW) & ~aw_done;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = (state == AW) & ~w_done;
  assign axi.bready  = (state == B);

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
module tb_data_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  data_sram_axi_bridge_if axi ();

  data_sram_axi_bridge dut (
    .clk               (clk),
    .resetn            (resetn),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .axi               (axi)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int          cycle = 0;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          issue;
    bit          chk_lat;
  } req_t;

  req_t resp_q[$];
  req_t ar_q[$];
  req_t aw_q[$];

  // Slave wait controls: -1 = random 0..3 cycles, otherwise fixed.
  int fw_ar = -1, fw_r = -1, fw_aw = -1, fw_w = -1, fw_b = -1;
  bit zero_mode = 1'b0;

  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] slv_mem [logic [29:0]];

  function automatic logic [31:0] dflt(input logic [29:0] w);
    return ({w, 2'b00} * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
  endfunction

  function logic [31:0] ref_rd(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
  endfunction

  function logic [31:0] slv_rd(input logic [29:0] w);
    return slv_mem.exists(w) ? slv_mem[w] : dflt(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) o[b*8 +: 8] = n[b*8 +: 8];
    return o;
  endfunction

  function automatic logic [2:0] exp_size(input logic [1:0] s);
    return (s == 2'd3) ? 3'd2 : {1'b0, s};
  endfunction

  function automatic int pick(input int f);
    return (f >= 0) ? f : int'($urandom_range(0, 3));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- AXI slave + channel checker ----------------
  int ar_wait, r_wait, aw_wait, w_wait, b_wait;
  bit ar_act, r_act, aw_act, w_act, b_act, aw_hs, w_hs;
  logic [31:0] r_addr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;

  initial begin
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        ar_act = 0; r_act = 0; aw_act = 0; w_act = 0; b_act = 0; aw_hs = 0; w_hs = 0;
        ar_q.delete(); aw_q.delete();
      end else begin
        if (aw_hs && !w_hs) begin
          check("awvalid_dropped", {31'b0, axi.awvalid}, 0);
          check("wvalid_held", {31'b0, axi.wvalid}, 1);
        end
        if (w_hs && !aw_hs) begin
          check("wvalid_dropped", {31'b0, axi.wvalid}, 0);
          check("awvalid_held", {31'b0, axi.awvalid}, 1);
        end
        // AR
        if (axi.arvalid) begin
          if (!ar_act) begin ar_act = 1; ar_wait = pick(fw_ar); end
          if (ar_q.size() == 0) check("ar_unexpected", ar_q.size(), 1);
          else check("araddr", axi.araddr, ar_q[0].addr);
          if (ar_wait > 0) begin
            axi.arready = 0; ar_wait--;
          end else begin
            axi.arready = 1;
            if (ar_q.size() != 0) begin
              check("arsize", {29'b0, axi.arsize}, {29'b0, exp_size(ar_q[0].size)});
              void'(ar_q.pop_front());
            end
            r_addr = axi.araddr;
            ar_act = 0;
          end
        end else axi.arready = 0;
        // R
        if (axi.rready) begin
          if (!r_act) begin r_act = 1; r_wait = pick(fw_r); end
          if (r_wait > 0) begin
            axi.rvalid = 0; axi.rdata = $urandom; r_wait--;
          end else begin
            axi.rvalid = 1; axi.rdata = slv_rd(r_addr[31:2]); r_act = 0;
          end
        end else begin
          axi.rvalid = 0; axi.rdata = $urandom;
        end
        // AW
        if (axi.awvalid) begin
          if (!aw_act) begin aw_act = 1; aw_wait = pick(fw_aw); end
          if (aw_wait > 0) begin
            axi.awready = 0; aw_wait--;
          end else begin
            axi.awready = 1; aw_hs = 1; aw_act = 0; cap_awaddr = axi.awaddr;
            if (aw_q.size() == 0) check("aw_unexpected", aw_q.size(), 1);
            else begin
              check("awaddr", axi.awaddr, aw_q[0].addr);
              check("awsize", {29'b0, axi.awsize}, {29'b0, exp_size(aw_q[0].size)});
            end
          end
        end else axi.awready = 0;
        // W
        if (axi.wvalid) begin
          if (!w_act) begin w_act = 1; w_wait = pick(fw_w); end
          if (w_wait > 0) begin
            axi.wready = 0; w_wait--;
          end else begin
            axi.wready = 1; w_hs = 1; w_act = 0;
            cap_wdata = axi.wdata; cap_wstrb = axi.wstrb;
            if (aw_q.size() != 0) begin
              check("wdata", axi.wdata, aw_q[0].wdata);
              check("wstrb", {28'b0, axi.wstrb}, {28'b0, aw_q[0].wstrb});
            end
          end
        end else axi.wready = 0;
        // B
        if (axi.bready) begin
          check("bready_after_both", {31'b0, aw_hs & w_hs}, 1);
          if (!b_act) begin b_act = 1; b_wait = pick(fw_b); end
          if (b_wait > 0) begin
            axi.bvalid = 0; b_wait--;
          end else begin
            axi.bvalid = 1; b_act = 0;
            slv_mem[cap_awaddr[31:2]] = merge(slv_rd(cap_awaddr[31:2]), cap_wdata, cap_wstrb);
            if (aw_q.size() != 0) void'(aw_q.pop_front());
            aw_hs = 0; w_hs = 0;
          end
        end else axi.bvalid = 0;
      end
    end
  end

  // ---------------- Response monitor / scoreboard ----------------
  initial forever begin
    req_t e;
    @(negedge clk);
    if (!resetn) resp_q.delete();
    else if (data_sram_data_ok) begin
      check("addr_ok_with_data_ok", {31'b0, data_sram_addr_ok}, 0);
      if (resp_q.size() == 0) check("spurious_data_ok", resp_q.size(), 1);
      else begin
        e = resp_q.pop_front();
        if (e.wr)
          ref_mem[e.addr[31:2]] = merge(ref_rd(e.addr[31:2]), e.wdata, e.wstrb);
        else
          check("rdata", data_sram_rdata, ref_rd(e.addr[31:2]));
        if (e.chk_lat) check("latency", cycle - e.issue, 3);
      end
    end
  end

  // ---------------- Driver ----------------
  task automatic set_waits(input int a, input int r, input int aw, input int w, input int b,
                           input bit z);
    fw_ar = a; fw_r = r; fw_aw = aw; fw_w = w; fw_b = b; zero_mode = z;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input bit keep,
                       output int acc_cycle);
    bit   got = 0;
    req_t e;
    acc_cycle = cycle;
    @(negedge clk);
    data_sram_req = 1; data_sram_wr = wr; data_sram_addr = addr;
    data_sram_size = size; data_sram_wdata = wdata; data_sram_wstrb = wstrb;
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      if (data_sram_addr_ok) begin
        got = 1; acc_cycle = cycle;
        e = '{wr, addr, size, wdata, wstrb, cycle, zero_mode};
        resp_q.push_back(e);
        if (wr) aw_q.push_back(e); else ar_q.push_back(e);
      end else @(negedge clk);
    end
    check("addr_ok_seen", {31'b0, got}, 1);
    @(negedge clk);
    if (keep) begin
      // Request stays asserted with unrelated fields; the bridge must ignore them.
      data_sram_wr = 1'($urandom); data_sram_addr = $urandom;
      data_sram_size = 2'($urandom); data_sram_wdata = $urandom; data_sram_wstrb = 4'($urandom);
    end else data_sram_req = 0;
  endtask

  task automatic wait_done(output int n_ok);
    bit seen = 0;
    n_ok = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (data_sram_data_ok) begin
        seen = 1; data_sram_req = 0;
      end else if (data_sram_addr_ok) n_ok++;
    end
    check("data_ok_seen", {31'b0, seen}, 1);
  endtask

  task automatic rand_txn();
    int c, n;
    logic [31:0] a;
    a = 32'h1000_0000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
    issue(1'($urandom), a, 2'($urandom), $urandom, 4'($urandom), 0, c);
    wait_done(n);
  endtask

  initial begin
    int c0, c1, c2, n;
    bit got;
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2, n;
    bit got;
    resetn = 0;
    data_sram_req = 1; data_sram_wr = 0; data_sram_size = 2'd2;
    data_sram_wstrb = 4'hF; data_sram_addr = 32'hFFFF_FFF0; data_sram_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    check("rst_addr_ok", {31'b0, data_sram_addr_ok}, 0);
    check("rst_data_ok", {31'b0, data_sram_data_ok}, 0);
    check("rst_arvalid", {31'b0, axi.arvalid}, 0);
    check("rst_rready",  {31'b0, axi.rready}, 0);
    check("rst_awvalid", {31'b0, axi.awvalid}, 0);
    check("rst_wvalid",  {31'b0, axi.wvalid}, 0);
    check("rst_bready",  {31'b0, axi.bready}, 0);
    check("rst_rdata",   data_sram_rdata, 0);
    check("rst_araddr",  axi.araddr, 0);
    check("rst_wdata",   axi.wdata, 0);
    check("rst_wstrb",   {28'b0, axi.wstrb}, 0);
    data_sram_req = 0;
    @(negedge clk);
    resetn = 1;

    // Zero-wait write then read of a known word.
    set_waits(0, 0, 0, 0, 0, 1);
    issue(1, 32'h1C00_0010, 2'd2, 32'hDEAD_BEEF, 4'hF, 0, c0); wait_done(n);
    issue(0, 32'h1C00_0010, 2'd2, 32'h0, 4'h0, 0, c0);         wait_done(n);

    // Skewed write channels: AW accepted two cycles before W.
    set_waits(0, 0, 0, 2, 1, 0);
    issue(1, 32'h0000_0008, 2'd2, 32'h1234_5678, 4'b0011, 0, c0); wait_done(n);
    set_waits(0, 0, 2, 0, 0, 0);
    issue(1, 32'h0000_000C, 2'd1, 32'hCAFE_F00D, 4'b1100, 0, c0); wait_done(n);
    set_waits(0, 0, 0, 0, 0, 1);
    issue(0, 32'h0000_0008, 2'd2, 32'h0, 4'h0, 0, c0); wait_done(n);
    issue(1, 32'h0000_0008, 2'd3, 32'h5555_AAAA, 4'b0000, 0, c0); wait_done(n);
    issue(0, 32'h0000_000C, 2'd3, 32'h0, 4'h0, 0, c0); wait_done(n);

    // Stall: arready held off 5 cycles, rvalid 3; request kept asserted meanwhile.
    set_waits(5, 3, 0, 0, 0, 0);
    issue(0, 32'h0000_0008, 2'd2, 32'h0, 4'h0, 1, c0); wait_done(n);
    check("addr_ok_during_stall", n, 0);

    // Back-to-back reads with request held high.
    set_waits(0, 0, 0, 0, 0, 1);
    issue(0, 32'h1C00_0010, 2'd2, 32'h0, 4'h0, 1, c0);
    issue(0, 32'h0000_0008, 2'd1, 32'h0, 4'h0, 1, c1);
    issue(0, 32'h0000_000C, 2'd0, 32'h0, 4'h0, 0, c2);
    wait_done(n);
    check("b2b_gap1", c1 - c0, 4);
    check("b2b_gap2", c2 - c1, 4);

    // Reset while waiting for the write response.
    set_waits(0, 0, 0, 0, 20, 0);
    issue(1, 32'h0000_0010, 2'd2, 32'h0BAD_0BAD, 4'hF, 0, c0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      #1;
      if (axi.bready) got = 1;
    end
    check("reached_b", {31'b0, got}, 1);
    data_sram_req = 1;
    resetn = 0;
    #1;
    check("mid_rst_arvalid", {31'b0, axi.arvalid}, 0);
    check("mid_rst_rready",  {31'b0, axi.rready}, 0);
    check("mid_rst_awvalid", {31'b0, axi.awvalid}, 0);
    check("mid_rst_wvalid",  {31'b0, axi.wvalid}, 0);
    check("mid_rst_bready",  {31'b0, axi.bready}, 0);
    check("mid_rst_addr_ok", {31'b0, data_sram_addr_ok}, 0);
    check("mid_rst_data_ok", {31'b0, data_sram_data_ok}, 0);
    check("mid_rst_rdata",   data_sram_rdata, 0);
    repeat (2) @(negedge clk);
    data_sram_req = 0;
    resetn = 1;
    set_waits(0, 0, 0, 0, 0, 1);
    issue(0, 32'h0000_0010, 2'd2, 32'h0, 4'h0, 0, c0); wait_done(n);

    // Randomized traffic: random slave waits, then zero-wait with latency checks.
    set_waits(-1, -1, -1, -1, -1, 0);
    for (int i = 0; i < 40; i++) rand_txn();
    set_waits(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) rand_txn();

    repeat (3) @(negedge clk);
    check("resp_q_drained", resp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
